// File: rtl/ysyx_22050550_wbu.sv
// ysyx_22050550_wbu -- write-back stage of the ysyx_22050550 core.
//
// Holds the final pipeline register before architectural state. It drives the
// integer register-file write port and the CSR write-back bus for the
// register/CSR block. It also resolves ecall/mret into a one-cycle PC redirect,
// counts retired instructions and reports the committed PC.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   in_*                  instruction handed over by MEM (valid/ready handshake)
//   mstatus_i/mtvec_i/mepc_i  live CSR values from the register/CSR block
//   io_valid/io_waddr/io_wdata/io_wen   integer register-file write port
//   wbm* / wbcsren        CSR write data and per-CSR write enables
//   redirect_valid/_pc    flush-and-fetch request for ecall/mret
//   commit_pc, minstret   committed PC and retired-instruction counter
module ysyx_22050550_wbu #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] ECALL_CAUSE = 64'd11
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    input  logic [XLEN-1:0] in_rd_data,
    input  logic [1:0]      in_csr_op,
    input  logic [11:0]     in_csr_addr,
    input  logic [XLEN-1:0] in_csr_wdata,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            io_valid,
    output logic [4:0]      io_waddr,
    output logic [XLEN-1:0] io_wdata,
    output logic            io_wen,
    output logic [XLEN-1:0] wbmepc,
    output logic [XLEN-1:0] wbmcause,
    output logic [XLEN-1:0] wbmtvec,
    output logic [XLEN-1:0] wbmstatus,
    output logic [XLEN-1:0] wbmie,
    output logic [XLEN-1:0] wbmip,
    output logic [7:0]      wbcsren,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] commit_pc,
    output logic [XLEN-1:0] minstret
);

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_CSRW  = 2'd1;
    localparam logic [1:0] OP_ECALL = 2'd2;
    localparam logic [1:0] OP_MRET  = 2'd3;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;

    typedef enum logic {RUN, TRAP} state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            rd_wen;
        logic [XLEN-1:0] rd_data;
        logic [1:0]      csr_op;
        logic [11:0]     csr_addr;
        logic [XLEN-1:0] csr_wdata;
    } stage_t;

    state_e          state_q, state_d;
    stage_t          stage_q, stage_d;
    logic [XLEN-1:0] minstret_q, minstret_d;
    logic            accept;

    assign in_ready = (state_q == RUN);
    assign accept   = in_valid && in_ready;

    // Stage register and FSM next state. The payload fields are left untouched
    // on a bubble; only the valid bit matters, and every output is gated by it.
    always_comb begin
        stage_d       = stage_q;
        stage_d.valid = 1'b0;
        state_d       = RUN;
        if (accept) begin
            stage_d.valid     = 1'b1;
            stage_d.pc        = in_pc;
            stage_d.rd        = in_rd;
            stage_d.rd_wen    = in_rd_wen;
            stage_d.rd_data   = in_rd_data;
            stage_d.csr_op    = in_csr_op;
            stage_d.csr_addr  = in_csr_addr;
            stage_d.csr_wdata = in_csr_wdata;
            if (in_csr_op == OP_ECALL || in_csr_op == OP_MRET) begin
                state_d = TRAP;
            end
        end
        // Every cycle with a valid stage retires its instruction.
        minstret_d = minstret_q + XLEN'(stage_q.valid);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            stage_q    <= '0;
            minstret_q <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            minstret_q <= minstret_d;
        end
    end

    // Write-back outputs, purely combinational from the stage and live CSRs.
    always_comb begin
        io_valid       = stage_q.valid;
        io_waddr       = '0;
        io_wdata       = '0;
        io_wen         = 1'b0;
        wbmepc         = '0;
        wbmcause       = '0;
        wbmtvec        = '0;
        wbmstatus      = '0;
        wbmie          = '0;
        wbmip          = '0;
        wbcsren        = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        commit_pc      = '0;

        if (stage_q.valid) begin
            io_waddr  = stage_q.rd;
            io_wdata  = stage_q.rd_data;
            io_wen    = stage_q.rd_wen && (stage_q.rd != 5'd0);
            commit_pc = stage_q.pc;

            unique case (stage_q.csr_op)
                OP_CSRW: begin
                    unique case (stage_q.csr_addr)
                        A_MEPC:    begin wbmepc    = stage_q.csr_wdata; wbcsren[0] = 1'b1; end
                        A_MCAUSE:  begin wbmcause  = stage_q.csr_wdata; wbcsren[1] = 1'b1; end
                        A_MTVEC:   begin wbmtvec   = stage_q.csr_wdata; wbcsren[2] = 1'b1; end
                        A_MSTATUS: begin wbmstatus = stage_q.csr_wdata; wbcsren[3] = 1'b1; end
                        A_MIE:     begin wbmie     = stage_q.csr_wdata; wbcsren[4] = 1'b1; end
                        A_MIP:     begin wbmip     = stage_q.csr_wdata; wbcsren[5] = 1'b1; end
                        default:   ;
                    endcase
                end
                OP_ECALL: begin
                    // Trap entry: stack MIE into MPIE, disable interrupts, MPP = M.
                    wbmepc          = stage_q.pc;
                    wbmcause        = ECALL_CAUSE;
                    wbmstatus       = mstatus_i;
                    wbmstatus[7]    = mstatus_i[3];
                    wbmstatus[3]    = 1'b0;
                    wbmstatus[12:11] = 2'b11;
                    wbcsren         = 8'b0000_1011;
                end
                OP_MRET: begin
                    // Trap return: restore MIE from MPIE, set MPIE, MPP stays M.
                    wbmstatus       = mstatus_i;
                    wbmstatus[3]    = mstatus_i[7];
                    wbmstatus[7]    = 1'b1;
                    wbmstatus[12:11] = 2'b11;
                    wbcsren         = 8'b0000_1000;
                end
                default: ;
            endcase

            // TRAP is only ever entered with the ecall/mret sitting in the stage.
            if (state_q == TRAP) begin
                redirect_valid = 1'b1;
                redirect_pc    = (stage_q.csr_op == OP_ECALL) ? {mtvec_i[XLEN-1:2], 2'b00}
                                                              : mepc_i;
            end
        end
    end

    assign minstret = minstret_q;

endmodule

// File: tb/tb_ysyx_22050550_wbu.sv
module tb_ysyx_22050550_wbu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic [4:0]  in_rd = '0;
    logic        in_rd_wen = 1'b0;
    logic [63:0] in_rd_data = '0;
    logic [1:0]  in_csr_op = '0;
    logic [11:0] in_csr_addr = '0;
    logic [63:0] in_csr_wdata = '0;
    logic [63:0] mstatus_i = '0, mtvec_i = '0, mepc_i = '0;
    logic        io_valid, io_wen, redirect_valid;
    logic [4:0]  io_waddr;
    logic [63:0] io_wdata, wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip;
    logic [7:0]  wbcsren;
    logic [63:0] redirect_pc, commit_pc, minstret;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction currently retiring (if any) and the count.
    bit          m_valid;
    bit          m_blocked;   // last accepted instruction was a trap: upstream blocked one cycle
    logic [63:0] m_pc, m_data, m_wd, m_minstret;
    logic [4:0]  m_rd;
    logic        m_wen;
    logic [1:0]  m_op;
    logic [11:0] m_addr;

    ysyx_22050550_wbu dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_rd_data(in_rd_data),
        .in_csr_op(in_csr_op), .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata),
        .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .io_valid(io_valid), .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wen(io_wen),
        .wbmepc(wbmepc), .wbmcause(wbmcause), .wbmtvec(wbmtvec), .wbmstatus(wbmstatus),
        .wbmie(wbmie), .wbmip(wbmip), .wbcsren(wbcsren),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .commit_pc(commit_pc), .minstret(minstret)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_valid = 0; m_blocked = 0; m_minstret = 0;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [4:0] rd,
                         input logic wen, input logic [63:0] data, input logic [1:0] op,
                         input logic [11:0] addr, input logic [63:0] wd);
        in_valid = v; in_pc = pc; in_rd = rd; in_rd_wen = wen; in_rd_data = data;
        in_csr_op = op; in_csr_addr = addr; in_csr_wdata = wd;
    endtask

    // Advance one rising edge and update the model; samples land 1ns after the edge.
    task automatic tick();
        bit acc;
        acc = in_valid && !m_blocked;
        @(posedge clock);
        if (m_valid) m_minstret = m_minstret + 64'd1;
        if (acc) begin
            m_valid = 1; m_pc = in_pc; m_rd = in_rd; m_wen = in_rd_wen; m_data = in_rd_data;
            m_op = in_csr_op; m_addr = in_csr_addr; m_wd = in_csr_wdata;
            m_blocked = (in_csr_op == 2'd2 || in_csr_op == 2'd3);
        end else begin
            m_valid = 0; m_blocked = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        #3;
        if ({io_valid, io_wen, redirect_valid, wbcsren} !== 11'd0 || minstret !== 64'd0) begin
            errors++; $display("FAIL reset_outputs got v=%0b wen=%0b red=%0b en=%h mi=%0d need all 0",
                               io_valid, io_wen, redirect_valid, wbcsren, minstret);
        end
        checks++;
        model_reset();
        @(negedge clock); reset = 0;
        #1;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b need 1", in_ready); end
        checks++;
    endtask

    task automatic test_addi();
        drive(1, 64'h8000_0000, 5'd5, 1, 64'h1234, 2'd0, 12'h0, 64'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        if (io_wen !== 1'b1 || io_waddr !== 5'd5 || io_wdata !== 64'h1234 || commit_pc !== 64'h8000_0000) begin
            errors++; $display("FAIL addi_write got wen=%b a=%0d d=%h pc=%h need 1 5 1234 80000000",
                               io_wen, io_waddr, io_wdata, commit_pc);
        end
        checks++;
        tick();
        if (minstret !== 64'd1 || io_valid !== 1'b0) begin
            errors++; $display("FAIL addi_minstret got %0d v=%b need 1 v=0", minstret, io_valid);
        end
        checks++;
    endtask

    task automatic test_x0();
        drive(1, 64'h8000_0004, 5'd0, 1, 64'hdead, 2'd0, 12'h0, 64'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        if (io_valid !== 1'b1 || io_wen !== 1'b0) begin
            errors++; $display("FAIL x0_write got v=%b wen=%b need v=1 wen=0", io_valid, io_wen);
        end
        checks++;
        tick();
        if (minstret !== 64'd2) begin errors++; $display("FAIL x0_minstret got %0d need 2", minstret); end
        checks++;
    endtask

    task automatic test_ecall();
        mtvec_i = 64'h8000_0201; mstatus_i = 64'h8;
        drive(1, 64'h8000_0100, 5'd0, 0, 0, 2'd2, 12'h0, 0);
        tick();
        // An instruction offered during TRAP must not be taken.
        drive(1, 64'h8000_0104, 5'd7, 1, 64'h77, 2'd0, 12'h0, 0);
        if (wbmepc !== 64'h8000_0100 || wbmcause !== 64'd11 || wbmstatus !== 64'h1880 || wbcsren !== 8'h0B) begin
            errors++; $display("FAIL ecall_csr got mepc=%h cause=%0d mstatus=%h en=%h need 80000100 11 1880 0b",
                               wbmepc, wbmcause, wbmstatus, wbcsren);
        end
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0200 || in_ready !== 1'b0) begin
            errors++; $display("FAIL ecall_redirect got rv=%b pc=%h rdy=%b need 1 80000200 0",
                               redirect_valid, redirect_pc, in_ready);
        end
        checks++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        if (redirect_valid !== 1'b0 || in_ready !== 1'b1 || io_valid !== 1'b0) begin
            errors++; $display("FAIL ecall_after got rv=%b rdy=%b v=%b need 0 1 0", redirect_valid, in_ready, io_valid);
        end
        checks++;
    endtask

    task automatic test_mret();
        mepc_i = 64'h8000_0104; mstatus_i = 64'h1880;
        drive(1, 64'h8000_0300, 5'd0, 0, 0, 2'd3, 12'h0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        if (wbmstatus !== 64'h1888 || wbcsren !== 8'h08 || redirect_pc !== 64'h8000_0104 || redirect_valid !== 1'b1) begin
            errors++; $display("FAIL mret got mstatus=%h en=%h rpc=%h rv=%b need 1888 08 80000104 1",
                               wbmstatus, wbcsren, redirect_pc, redirect_valid);
        end
        checks++;
        tick();
        if (redirect_valid !== 1'b0) begin errors++; $display("FAIL mret_one_cycle got rv=%b need 0", redirect_valid); end
        checks++;
    endtask

    task automatic test_csrw();
        drive(1, 64'h8000_0400, 5'd0, 0, 0, 2'd1, 12'h305, 64'h8000_0000);
        tick();
        drive(1, 64'h8000_0404, 5'd0, 0, 0, 2'd1, 12'h7C0, 64'h1234);
        if (wbcsren !== 8'h04 || wbmtvec !== 64'h8000_0000 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL csrw_mtvec got en=%h mtvec=%h rv=%b need 04 80000000 0", wbcsren, wbmtvec, redirect_valid);
        end
        checks++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        if (wbcsren !== 8'h00 || io_valid !== 1'b1) begin
            errors++; $display("FAIL csrw_unknown got en=%h v=%b need 00 1", wbcsren, io_valid);
        end
        checks++;
        tick();
    endtask

    task automatic test_random();
        logic [11:0] addrs [7];
        logic [63:0] e_st, e_rpc, e_wb [6];
        logic [7:0]  e_en;
        logic        e_rv;
        addrs = '{12'h341, 12'h342, 12'h305, 12'h300, 12'h304, 12'h344, 12'h7C0};
        for (int n = 0; n < 400; n++) begin
            if (in_ready !== !m_blocked) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b need %b", n, in_ready, !m_blocked);
            end
            checks++;
            drive(($urandom_range(3) != 0), {$urandom, $urandom}, 5'($urandom_range(31)),
                  1'($urandom), {$urandom, $urandom}, 2'($urandom_range(3)),
                  addrs[$urandom_range(6)], {$urandom, $urandom});
            mstatus_i = {$urandom, $urandom}; mtvec_i = {$urandom, $urandom}; mepc_i = {$urandom, $urandom};
            tick();
            // Expected outputs from the architectural rules.
            e_en = 0; e_rv = 0; e_rpc = 0; e_st = 0;
            foreach (e_wb[i]) e_wb[i] = 0;
            if (m_valid) begin
                if (m_op == 2'd1) begin
                    for (int i = 0; i < 6; i++)
                        if (m_addr == addrs[i]) begin e_en = 8'(1 << i); e_wb[i] = m_wd; end
                end else if (m_op == 2'd2) begin
                    e_st = (mstatus_i & ~64'h1888) | (((mstatus_i >> 3) & 64'd1) << 7) | 64'h1800;
                    e_wb[0] = m_pc; e_wb[1] = 64'd11; e_wb[3] = e_st;
                    e_en = 8'h0B; e_rv = 1; e_rpc = mtvec_i & ~64'd3;
                end else if (m_op == 2'd3) begin
                    e_st = (mstatus_i & ~64'h1888) | (((mstatus_i >> 7) & 64'd1) << 3) | 64'h1880;
                    e_wb[3] = e_st; e_en = 8'h08; e_rv = 1; e_rpc = mepc_i;
                end
            end
            if (io_valid !== m_valid || io_wen !== (m_valid && m_wen && m_rd != 0) ||
                (m_valid && (io_waddr !== m_rd || io_wdata !== m_data || commit_pc !== m_pc))) begin
                errors++; $display("FAIL rnd_rf cyc %0d got v=%b wen=%b a=%0d d=%h need v=%b rd=%0d d=%h",
                                   n, io_valid, io_wen, io_waddr, io_wdata, m_valid, m_rd, m_data);
            end
            checks++;
            if (wbcsren !== e_en || wbmepc !== e_wb[0] || wbmcause !== e_wb[1] || wbmtvec !== e_wb[2] ||
                wbmstatus !== e_wb[3] || wbmie !== e_wb[4] || wbmip !== e_wb[5]) begin
                errors++; $display("FAIL rnd_csr cyc %0d got en=%h mst=%h need en=%h mst=%h",
                                   n, wbcsren, wbmstatus, e_en, e_wb[3]);
            end
            checks++;
            if (redirect_valid !== e_rv || redirect_pc !== e_rpc || minstret !== m_minstret) begin
                errors++; $display("FAIL rnd_redir cyc %0d got rv=%b pc=%h mi=%0d need %b %h %0d",
                                   n, redirect_valid, redirect_pc, minstret, e_rv, e_rpc, m_minstret);
            end
            checks++;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_midflight();
        drive(1, 64'h8000_0500, 5'd9, 1, 64'h55, 2'd0, 12'h0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        if (io_wen !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got wen=%b need 1", io_wen); end
        checks++;
        #1 reset = 1; #1;
        model_reset();
        if (io_wen !== 1'b0 || io_valid !== 1'b0 || minstret !== 64'd0) begin
            errors++; $display("FAIL rst_mid_drop got wen=%b v=%b mi=%0d need 0 0 0", io_wen, io_valid, minstret);
        end
        checks++;
        @(negedge clock); reset = 0;
        tick();
        if (redirect_valid !== 1'b0 || io_valid !== 1'b0 || minstret !== 64'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_after got rv=%b v=%b mi=%0d rdy=%b need 0 0 0 1",
                               redirect_valid, io_valid, minstret, in_ready);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_x0();
        test_ecall();
        test_mret();
        test_csrw();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
